// File: rtl/axis_pkg_receiver_if.sv
// axis_pkg_receiver_if
// Bundles the beat stream (tvalid/tready/tdata/tlast) and the packet-word
// output handshake (pkt_valid/pkt_ready/pkt_data) of the packet receiver.
//   slave  : receiver side (consumes beats, produces packet words)
//   master : environment side (produces beats, consumes packet words)
// Parameters: DATA_W beat width, BEATS beats per packet; WORD_W is derived.
interface axis_pkg_receiver_if #(
    parameter int DATA_W = 3,
    parameter int BEATS  = 2
);
    localparam int WORD_W = DATA_W * BEATS;

    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic              tlast;
    logic              pkt_valid;
    logic              pkt_ready;
    logic [WORD_W-1:0] pkt_data;

    modport slave (
        input  tvalid, tdata, tlast, pkt_ready,
        output tready, pkt_valid, pkt_data
    );

    modport master (
        output tvalid, tdata, tlast, pkt_ready,
        input  tready, pkt_valid, pkt_data
    );
endinterface

// File: rtl/axis_pkg_receiver.sv
// axis_pkg_receiver
// Terminates the counter-packet stream: assembles BEATS beats of DATA_W bits
// (LSB-first, tlast on the final beat) into one packet word, flags short and
// long packets, and buffers finished words in a 2-entry queue.
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   bus        axis_pkg_receiver_if.slave (beat stream in, packet words out)
//   err_short  one-cycle pulse, tlast before BEATS beats
//   err_long   one-cycle pulse, BEATS beats without tlast
//   err_seq    one-cycle pulse, sequence gap (only with SEQ_CHECK_EN)
//   err_cnt    saturating count of error pulses
//   pkt_cnt    wrapping count of packets pushed into the queue
// Optional feature: define SEQ_CHECK_EN to enable the sequence-gap checker.
module axis_pkg_receiver #(
    parameter int DATA_W = 3,
    parameter int BEATS  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    axis_pkg_receiver_if.slave     bus,
    output logic                   err_short,
    output logic                   err_long,
    output logic                   err_seq,
    output logic [7:0]             err_cnt,
    output logic [15:0]            pkt_cnt
);
    localparam int WORD_W = DATA_W * BEATS;
    localparam int CNT_W  = (BEATS > 2) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DROP    = 2'd2
    } state_t;

    state_t             state_r, state_s;
    logic [CNT_W-1:0]   beat_cnt_r, beat_cnt_s;
    logic [WORD_W-1:0]  asm_r, asm_s;
    logic [WORD_W-1:0]  word_s;
    logic               accept_s;
    logic               complete_s, short_s, long_s, seq_s;

    // Output queue: head register feeds pkt_data directly, tail is the spare.
    logic [WORD_W-1:0]  head_r, head_s, tail_r, tail_s;
    logic               head_vld_r, head_vld_s, tail_vld_r, tail_vld_s;
    logic               pop_s;
    logic               tready_r, tready_s;

    logic               err_short_r, err_long_r;
    logic [7:0]         err_cnt_r, err_cnt_s;
    logic [8:0]         err_sum_s;
    logic [15:0]        pkt_cnt_r;

    assign accept_s = bus.tvalid & tready_r;
    assign pop_s    = head_vld_r & bus.pkt_ready;

    // Packet assembly state machine: next state, beat slot and error decode.
    always_comb begin
        state_s    = state_r;
        beat_cnt_s = beat_cnt_r;
        asm_s      = asm_r;
        complete_s = 1'b0;
        short_s    = 1'b0;
        long_s     = 1'b0;
        word_s     = asm_r;
        word_s[int'(beat_cnt_r) * DATA_W +: DATA_W] = bus.tdata;
        case (state_r)
            ST_IDLE, ST_COLLECT: begin
                if (accept_s) begin
                    asm_s = word_s;
                    if (bus.tlast) begin
                        if (beat_cnt_r == LAST_IDX) begin
                            complete_s = 1'b1;
                        end else begin
                            short_s = 1'b1;
                        end
                        state_s    = ST_IDLE;
                        beat_cnt_s = {CNT_W{1'b0}};
                    end else if (beat_cnt_r == LAST_IDX) begin
                        // Slot full but no tlast: discard until the real tlast.
                        long_s     = 1'b1;
                        state_s    = ST_DROP;
                        beat_cnt_s = {CNT_W{1'b0}};
                    end else begin
                        state_s    = ST_COLLECT;
                        beat_cnt_s = beat_cnt_r + 1'b1;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            ST_DROP: begin
                if (accept_s && bus.tlast) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DROP;
                end
            end
            default: begin
                state_s    = ST_IDLE;
                beat_cnt_s = {CNT_W{1'b0}};
            end
        endcase
    end

    // Queue next-state: pop shifts tail into head, push fills the first free slot.
    always_comb begin
        head_s     = head_r;
        tail_s     = tail_r;
        head_vld_s = head_vld_r;
        tail_vld_s = tail_vld_r;
        case ({tail_vld_r, head_vld_r})
            2'b00: begin
                if (complete_s) begin
                    head_s     = word_s;
                    head_vld_s = 1'b1;
                end else begin
                    head_vld_s = 1'b0;
                end
            end
            2'b01: begin
                case ({complete_s, pop_s})
                    2'b11: head_s = word_s;
                    2'b10: begin
                        tail_s     = word_s;
                        tail_vld_s = 1'b1;
                    end
                    2'b01: head_vld_s = 1'b0;
                    default: head_vld_s = 1'b1;
                endcase
            end
            2'b11: begin
                if (pop_s) begin
                    head_s = tail_r;
                    if (complete_s) begin
                        tail_s = word_s;
                    end else begin
                        tail_vld_s = 1'b0;
                    end
                end else begin
                    tail_vld_s = 1'b1;
                end
            end
            default: begin
                head_vld_s = 1'b0;
                tail_vld_s = 1'b0;
            end
        endcase
        tready_s = ~(head_vld_s & tail_vld_s);
    end

    // Error counter: add this cycle's pulses, clamp at 255.
    always_comb begin
        err_sum_s = {1'b0, err_cnt_r} + {8'd0, short_s} + {8'd0, long_s} + {8'd0, seq_s};
        if (err_sum_s[8]) begin
            err_cnt_s = 8'd255;
        end else begin
            err_cnt_s = err_sum_s[7:0];
        end
    end

    // Main state, queue, handshake and status registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            beat_cnt_r  <= {CNT_W{1'b0}};
            asm_r       <= {WORD_W{1'b0}};
            head_r      <= {WORD_W{1'b0}};
            tail_r      <= {WORD_W{1'b0}};
            head_vld_r  <= 1'b0;
            tail_vld_r  <= 1'b0;
            tready_r    <= 1'b0;
            err_short_r <= 1'b0;
            err_long_r  <= 1'b0;
            err_cnt_r   <= 8'd0;
            pkt_cnt_r   <= 16'd0;
        end else begin
            state_r     <= state_s;
            beat_cnt_r  <= beat_cnt_s;
            asm_r       <= asm_s;
            head_r      <= head_s;
            tail_r      <= tail_s;
            head_vld_r  <= head_vld_s;
            tail_vld_r  <= tail_vld_s;
            tready_r    <= tready_s;
            err_short_r <= short_s;
            err_long_r  <= long_s;
            err_cnt_r   <= err_cnt_s;
            if (complete_s) begin
                pkt_cnt_r <= pkt_cnt_r + 16'd1;
            end else begin
                pkt_cnt_r <= pkt_cnt_r;
            end
        end
    end

`ifdef SEQ_CHECK_EN
    localparam logic [WORD_W-1:0] ONE_W = {{(WORD_W-1){1'b0}}, 1'b1};

    logic [WORD_W-1:0] ref_r;
    logic [WORD_W-1:0] ref_inc_s;
    logic              ref_vld_r;
    logic              err_seq_r;

    assign ref_inc_s = ref_r + ONE_W;

    // Gap detect: words 0 and 1 are counter restarts and never flagged.
    always_comb begin
        seq_s = 1'b0;
        if (complete_s && ref_vld_r && (word_s != ref_inc_s) && (word_s > ONE_W)) begin
            seq_s = 1'b1;
        end else begin
            seq_s = 1'b0;
        end
    end

    // Sequence reference tracks the most recent completed word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ref_r     <= {WORD_W{1'b0}};
            ref_vld_r <= 1'b0;
            err_seq_r <= 1'b0;
        end else begin
            err_seq_r <= seq_s;
            if (complete_s) begin
                ref_r     <= word_s;
                ref_vld_r <= 1'b1;
            end else begin
                ref_r     <= ref_r;
                ref_vld_r <= ref_vld_r;
            end
        end
    end

    assign err_seq = err_seq_r;
`else
    assign seq_s   = 1'b0;
    assign err_seq = 1'b0;
`endif

    assign bus.tready    = tready_r;
    assign bus.pkt_valid = head_vld_r;
    assign bus.pkt_data  = head_r;
    assign err_short     = err_short_r;
    assign err_long      = err_long_r;
    assign err_cnt       = err_cnt_r;
    assign pkt_cnt       = pkt_cnt_r;
endmodule
